// File: rtl/card_draw_ctl.sv
// Card sprite scheduler: resolves the top-most visible card slot per pixel, addresses the
// shared suit ROM and overlays its pixels on the VGA stream with a fixed 3-cycle latency.
module card_draw_ctl #(
    parameter int                    ADDR_WIDTH = 13,
    parameter int                    DATA_WIDTH = 12,
    parameter int                    SLOTS      = 8,
    parameter int                    CARD_W     = 64,
    parameter int                    CARD_H     = 128,
    parameter int                    HW         = 11,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR  = 12'hF0F,
    localparam int                   SW         = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [HW-1:0]         hcount_in,
    input  logic [HW-1:0]         vcount_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  hblnk_in,
    input  logic                  vblnk_in,
    input  logic [DATA_WIDTH-1:0] rgb_in,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [SW-1:0]         cfg_slot,
    input  logic                  cfg_en,
    input  logic [HW-1:0]         cfg_x,
    input  logic [HW-1:0]         cfg_y,
    input  logic [1:0]            cfg_symbol,
    input  logic                  cfg_commit,
    output logic                  commit_done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [1:0]            rom_symbol,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [HW-1:0]         hcount_out,
    output logic [HW-1:0]         vcount_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  hblnk_out,
    output logic                  vblnk_out,
    output logic [DATA_WIDTH-1:0] rgb_out
);

    localparam int        CWB    = $clog2(CARD_W);
    localparam int        CHB    = $clog2(CARD_H);
    localparam logic [HW:0] CW_EXT = (HW+1)'(CARD_W);
    localparam logic [HW:0] CH_EXT = (HW+1)'(CARD_H);

    typedef enum logic [1:0] {OPEN, PENDING, COPY} cfg_state_t;

    cfg_state_t state, state_nxt;
    logic       vblnk_prev;

    logic          sh_en  [SLOTS];
    logic [HW-1:0] sh_x   [SLOTS];
    logic [HW-1:0] sh_y   [SLOTS];
    logic [1:0]    sh_sym [SLOTS];
    logic          ac_en  [SLOTS];
    logic [HW-1:0] ac_x   [SLOTS];
    logic [HW-1:0] ac_y   [SLOTS];
    logic [1:0]    ac_sym [SLOTS];

    function automatic logic [DATA_WIDTH-1:0] pixel_mux(
        input logic                  blank,
        input logic                  hit,
        input logic [DATA_WIDTH-1:0] rom,
        input logic [DATA_WIDTH-1:0] bg
    );
        if (blank)
            return '0;
        else if (hit && rom != KEY_COLOR)
            return rom;
        else
            return bg;
    endfunction

    always_comb begin
        state_nxt   = state;
        cfg_ready   = 1'b0;
        commit_done = 1'b0;
        case (state)
            OPEN: begin
                cfg_ready = 1'b1;
                if (cfg_commit)
                    state_nxt = PENDING;
            end
            PENDING: begin
                if (vblnk_in && !vblnk_prev)
                    state_nxt = COPY;
            end
            COPY: begin
                commit_done = 1'b1;
                state_nxt   = OPEN;
            end
            default: state_nxt = OPEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= OPEN;
            vblnk_prev <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                sh_en[i]  <= 1'b0;
                sh_x[i]   <= '0;
                sh_y[i]   <= '0;
                sh_sym[i] <= '0;
                ac_en[i]  <= 1'b0;
                ac_x[i]   <= '0;
                ac_y[i]   <= '0;
                ac_sym[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            vblnk_prev <= vblnk_in;
            if (cfg_valid && cfg_ready) begin
                sh_en[cfg_slot]  <= cfg_en;
                sh_x[cfg_slot]   <= cfg_x;
                sh_y[cfg_slot]   <= cfg_y;
                sh_sym[cfg_slot] <= cfg_symbol;
            end
            if (state == COPY) begin
                for (int i = 0; i < SLOTS; i++) begin
                    ac_en[i]  <= sh_en[i];
                    ac_x[i]   <= sh_x[i];
                    ac_y[i]   <= sh_y[i];
                    ac_sym[i] <= sh_sym[i];
                end
            end
        end
    end

    // Slot hit resolution; coordinates widened by one bit so x+CARD_W cannot wrap.
    logic                  any_hit;
    logic [1:0]            win_sym;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [HW:0]           h_ext, v_ext, x_ext, y_ext, dh, dv;

    always_comb begin
        any_hit  = 1'b0;
        win_sym  = '0;
        win_addr = '0;
        h_ext    = {1'b0, hcount_in};
        v_ext    = {1'b0, vcount_in};
        x_ext    = '0;
        y_ext    = '0;
        dh       = '0;
        dv       = '0;
        for (int i = 0; i < SLOTS; i++) begin
            x_ext = {1'b0, ac_x[i]};
            y_ext = {1'b0, ac_y[i]};
            dh    = h_ext - x_ext;
            dv    = v_ext - y_ext;
            if (ac_en[i] && h_ext >= x_ext && h_ext < x_ext + CW_EXT &&
                v_ext >= y_ext && v_ext < y_ext + CH_EXT) begin
                any_hit  = 1'b1;
                win_sym  = ac_sym[i];
                win_addr = ADDR_WIDTH'({dv[CHB-1:0], dh[CWB-1:0]});
            end
        end
    end

    logic [HW-1:0]         hcount_p1, vcount_p1, hcount_p2, vcount_p2;
    logic                  hsync_p1, vsync_p1, hblnk_p1, vblnk_p1, hit_p1;
    logic                  hsync_p2, vsync_p2, hblnk_p2, vblnk_p2, hit_p2;
    logic [DATA_WIDTH-1:0] rgb_p1, rgb_p2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_p1     <= 1'b0;
            hit_p2     <= 1'b0;
            rom_addr   <= '0;
            rom_symbol <= '0;
            hcount_p1  <= '0;
            vcount_p1  <= '0;
            hsync_p1   <= 1'b0;
            vsync_p1   <= 1'b0;
            hblnk_p1   <= 1'b0;
            vblnk_p1   <= 1'b0;
            rgb_p1     <= '0;
            hcount_p2  <= '0;
            vcount_p2  <= '0;
            hsync_p2   <= 1'b0;
            vsync_p2   <= 1'b0;
            hblnk_p2   <= 1'b0;
            vblnk_p2   <= 1'b0;
            rgb_p2     <= '0;
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            // Stage 1: address the ROM for the winning slot; hold the address otherwise.
            hit_p1 <= any_hit && !hblnk_in && !vblnk_in;
            if (any_hit && !hblnk_in && !vblnk_in) begin
                rom_addr   <= win_addr;
                rom_symbol <= win_sym;
            end
            hcount_p1 <= hcount_in;
            vcount_p1 <= vcount_in;
            hsync_p1  <= hsync_in;
            vsync_p1  <= vsync_in;
            hblnk_p1  <= hblnk_in;
            vblnk_p1  <= vblnk_in;
            rgb_p1    <= rgb_in;
            // Stage 2: ROM read in flight.
            hit_p2    <= hit_p1;
            hcount_p2 <= hcount_p1;
            vcount_p2 <= vcount_p1;
            hsync_p2  <= hsync_p1;
            vsync_p2  <= vsync_p1;
            hblnk_p2  <= hblnk_p1;
            vblnk_p2  <= vblnk_p1;
            rgb_p2    <= rgb_p1;
            // Stage 3: overlay.
            hcount_out <= hcount_p2;
            vcount_out <= vcount_p2;
            hsync_out  <= hsync_p2;
            vsync_out  <= vsync_p2;
            hblnk_out  <= hblnk_p2;
            vblnk_out  <= vblnk_p2;
            rgb_out    <= pixel_mux(hblnk_p2 || vblnk_p2, hit_p2, rom_data, rgb_p2);
        end
    end

endmodule

// File: tb/tb_card_draw_ctl.sv
// Bench for card_draw_ctl: directed vector table and sequences, then random traffic
// checked every cycle against a slot-table/pixel-queue reference model.
module tb_card_draw_ctl;

    localparam logic [11:0] KEY = 12'hF0F;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic        cfg_valid, cfg_ready, cfg_en, cfg_commit, commit_done;
    logic [2:0]  cfg_slot;
    logic [10:0] cfg_x, cfg_y;
    logic [1:0]  cfg_symbol, rom_symbol;
    logic [12:0] rom_addr;
    logic [11:0] rom_data;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    card_draw_ctl dut (
        .clk(clk), .rst_n(rst_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_slot(cfg_slot), .cfg_en(cfg_en),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_symbol(cfg_symbol), .cfg_commit(cfg_commit),
        .commit_done(commit_done),
        .rom_addr(rom_addr), .rom_symbol(rom_symbol), .rom_data(rom_data),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    // Behavioural ROM: mode 0 = pattern, 1 = transparent key, 2 = solid 12'h123.
    int rom_mode;
    function automatic logic [11:0] rom_val(int mode, int sym, int addr);
        logic [11:0] v;
        if (mode == 1)      v = KEY;
        else if (mode == 2) v = 12'h123;
        else                v = 12'((sym % 4) * 1024 + (addr % 1024));
        return v;
    endfunction
    always @(posedge clk) rom_data <= rom_val(rom_mode, int'(rom_symbol), int'(rom_addr));

    int n_pass = 0;
    int n_total = 0;

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct { bit en; int x; int y; int sym; } slot_t;
    typedef struct { int hc; int vc; bit hs; bit vs; bit hb; bit vb; int rgb; bit hit; } pix_t;
    slot_t m_sh[8], m_ac[8];
    pix_t  m_p1, m_p2, m_out;
    int    m_phase;       // 0 accepting writes, 1 waiting for vblank, 2 publishing
    bit    m_prev_vb;
    int    m_addr, m_sym, m_rdata;
    bit    model_on = 0;

    task automatic model_edge();
        pix_t  cur;
        int    w, h, v;
        if (!rst_n) begin
            m_rdata = rom_val(rom_mode, m_sym, m_addr);
            for (int i = 0; i < 8; i++) begin
                m_sh[i] = '{0, 0, 0, 0};
                m_ac[i] = '{0, 0, 0, 0};
            end
            m_p1 = '{0, 0, 0, 0, 0, 0, 0, 0};
            m_p2 = m_p1;
            m_out = m_p1;
            m_phase = 0;
            m_prev_vb = 0;
            m_addr = 0;
            m_sym = 0;
            model_on = 1;
            return;
        end
        m_out = m_p2;
        if (m_p2.hb || m_p2.vb) m_out.rgb = 0;
        else if (m_p2.hit && m_rdata != int'(KEY)) m_out.rgb = m_rdata;
        m_rdata = rom_val(rom_mode, m_sym, m_addr);
        m_p2 = m_p1;
        h = int'(hcount_in);
        v = int'(vcount_in);
        w = -1;
        for (int i = 7; i >= 0; i--)
            if (w < 0 && m_ac[i].en && h >= m_ac[i].x && h < m_ac[i].x + 64 &&
                v >= m_ac[i].y && v < m_ac[i].y + 128)
                w = i;
        cur = '{h, v, hsync_in, vsync_in, hblnk_in, vblnk_in, int'(rgb_in), 0};
        cur.hit = (w >= 0) && !hblnk_in && !vblnk_in;
        if (cur.hit) begin
            m_addr = (v - m_ac[w].y) * 64 + (h - m_ac[w].x);
            m_sym  = m_ac[w].sym;
        end
        m_p1 = cur;
        if (m_phase == 0) begin
            if (cfg_valid)
                m_sh[cfg_slot] = '{cfg_en, int'(cfg_x), int'(cfg_y), int'(cfg_symbol)};
            if (cfg_commit) m_phase = 1;
        end else if (m_phase == 1) begin
            if (vblnk_in && !m_prev_vb) m_phase = 2;
        end else begin
            m_ac = m_sh;
            m_phase = 0;
        end
        m_prev_vb = vblnk_in;
    endtask

    task automatic tick();
        logic [63:0] got, want;
        @(posedge clk);
        model_edge();
        #1;
        if (model_on) begin
            got = {9'd0, cfg_ready, commit_done, rom_addr, rom_symbol, hcount_out, vcount_out,
                   hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
            want = {9'd0, m_phase == 0, m_phase == 2, 13'(m_addr), 2'(m_sym), 11'(m_out.hc),
                    11'(m_out.vc), m_out.hs, m_out.vs, m_out.hb, m_out.vb, 12'(m_out.rgb)};
            check("model", got, want);
        end
    endtask

    task automatic tick_n(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg_write(int s, bit en, int x, int y, int sym);
        cfg_valid = 1; cfg_slot = 3'(s); cfg_en = en;
        cfg_x = 11'(x); cfg_y = 11'(y); cfg_symbol = 2'(sym);
        tick();
        cfg_valid = 0;
    endtask

    task automatic commit();
        cfg_commit = 1;
        tick();
        cfg_commit = 0;
    endtask

    task automatic vblank_pulse(bit expect_done);
        vblnk_in = 1;
        tick();
        check("commit_done_pulse", 64'(commit_done), 64'(expect_done));
        tick();
        check("commit_done_drop", 64'(commit_done), 64'd0);
        vblnk_in = 0;
        tick();
    endtask

    task automatic pixel_rgb(string name, int h, int v, logic [11:0] want);
        hcount_in = 11'(h); vcount_in = 11'(v);
        tick_n(3);
        check(name, 64'(rgb_out), 64'(want));
    endtask

    typedef struct { int h; int v; int addr; int sym; logic [11:0] rgb; } vec_t;
    vec_t tbl[8];

    task automatic run_vec(int i);
        hcount_in = 11'(tbl[i].h); vcount_in = 11'(tbl[i].v); rgb_in = 12'h0A0;
        tick();
        check($sformatf("vec%0d_addr", i), 64'(rom_addr), 64'(tbl[i].addr));
        check($sformatf("vec%0d_sym", i), 64'(rom_symbol), 64'(tbl[i].sym));
        tick_n(2);
        check($sformatf("vec%0d_rgb", i), 64'(rgb_out), 64'(tbl[i].rgb));
    endtask

    initial begin
        tbl[0] = '{100,  50,    0, 2, 12'h123};
        tbl[1] = '{163, 177, 8191, 2, 12'h123};
        tbl[2] = '{164,  50, 8191, 2, 12'h0A0};
        tbl[3] = '{ 99,  50, 8191, 2, 12'h0A0};
        tbl[4] = '{130,  70,  650, 3, 12'h123};
        tbl[5] = '{110,  55,  330, 2, 12'h123};
        tbl[6] = '{183, 187, 8191, 3, 12'h123};
        tbl[7] = '{184, 187, 8191, 3, 12'h0A0};

        rst_n = 0; rom_mode = 0;
        hcount_in = 0; vcount_in = 0; hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
        rgb_in = 0; cfg_valid = 0; cfg_slot = 0; cfg_en = 0; cfg_x = 0; cfg_y = 0;
        cfg_symbol = 0; cfg_commit = 0;
        #2;

        // Reset
        tick_n(2);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("rst_commit_done", 64'(commit_done), 64'd0);
        check("rst_rom_addr", 64'(rom_addr), 64'd0);
        check("rst_rgb_out", 64'(rgb_out), 64'd0);
        check("rst_timing", {58'd0, hsync_out, vsync_out, hblnk_out, vblnk_out, |hcount_out, |vcount_out}, 64'd0);
        rst_n = 1; rgb_in = 12'h0A0; hcount_in = 5; vcount_in = 5;
        tick_n(3);
        check("bg_passthrough", 64'(rgb_out), 64'h0A0);

        // Single card, then overlap
        rom_mode = 2;
        cfg_write(0, 1, 100, 50, 2);
        commit();
        check("pending_ready", 64'(cfg_ready), 64'd0);
        vblank_pulse(1);
        for (int i = 0; i < 4; i++) run_vec(i);
        cfg_write(1, 1, 120, 60, 3);
        commit();
        vblank_pulse(1);
        for (int i = 4; i < 8; i++) run_vec(i);

        // Transparency
        rom_mode = 1; pixel_rgb("key_transparent", 130, 70, 12'h0A0);
        rom_mode = 2; pixel_rgb("rom_opaque", 130, 70, 12'h123);
        rom_mode = 0; pixel_rgb("rom_pattern", 130, 70, 12'hE8A);
        rom_mode = 2;

        // Mid-frame commit must not tear
        hcount_in = 10; vcount_in = 200;
        cfg_write(0, 0, 100, 50, 2);
        commit();
        check("tear_ready_low", 64'(cfg_ready), 64'd0);
        cfg_write(1, 0, 0, 0, 0);
        check("tear_ready_still_low", 64'(cfg_ready), 64'd0);
        pixel_rgb("tear_old_visible", 100, 50, 12'h123);
        vblank_pulse(1);
        pixel_rgb("tear_new_visible", 100, 50, 12'h0A0);
        pixel_rgb("tear_write_ignored", 130, 70, 12'h123);

        // Right-edge card must not wrap to h=0
        cfg_write(3, 1, 2037, 0, 1);
        commit();
        vblank_pulse(1);
        for (int h = 0; h < 6; h++) pixel_rgb($sformatf("nowrap_h%0d", h), h, 10, 12'h0A0);
        hcount_in = 2040; vcount_in = 10;
        tick();
        check("edge_addr", 64'(rom_addr), 64'd643);
        check("edge_sym", 64'(rom_symbol), 64'd1);

        // Reset while a commit is pending
        cfg_write(4, 1, 0, 0, 0);
        commit();
        rst_n = 0;
        tick_n(2);
        check("abort_ready", 64'(cfg_ready), 64'd1);
        rst_n = 1;
        vblank_pulse(0);
        pixel_rgb("abort_empty_slot4", 10, 10, 12'h0A0);
        pixel_rgb("abort_empty_slot1", 130, 70, 12'h0A0);

        // Random traffic against the reference model
        for (int n = 0; n < 4000; n++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 15) == 0) rom_mode = int'($urandom_range(0, 2));
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_slot   = 3'($urandom_range(0, 7));
            cfg_en     = ($urandom_range(0, 4) != 0);
            cfg_x      = 11'(($urandom_range(0, 9) == 0) ? $urandom_range(1980, 2047) : $urandom_range(0, 600));
            cfg_y      = 11'($urandom_range(0, 400));
            cfg_symbol = 2'($urandom_range(0, 3));
            cfg_commit = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 39) == 0) vblnk_in = ~vblnk_in;
            hblnk_in   = ($urandom_range(0, 7) == 0);
            hsync_in   = 1'($urandom_range(0, 1));
            vsync_in   = 1'($urandom_range(0, 1));
            hcount_in  = 11'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 700));
            vcount_in  = 11'($urandom_range(0, 560));
            rgb_in     = 12'($urandom_range(0, 4095));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
